// File: rtl/i2c_seq_ctrl.sv
// i2c_seq_ctrl: replaces a CPU on the i2c_master_regs register bus and
// runs one complete I2C register write or register read per request.
module i2c_seq_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8,
    parameter logic [7:0] PRESCALE = 8'd49,
    parameter int TO_CYCLES = 4095,
    parameter logic [AWIDTH-1:0] PRER_A = 3'h0,
    parameter logic [AWIDTH-1:0] CTR_A = 3'h1,
    parameter logic [AWIDTH-1:0] TXR_A = 3'h2,
    parameter logic [AWIDTH-1:0] RXR_A = 3'h2,
    parameter logic [AWIDTH-1:0] CR_A = 3'h3,
    parameter logic [AWIDTH-1:0] SR_A = 3'h3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req,
    input  logic              Rnw,
    input  logic [6:0]        Slv_addr,
    input  logic [7:0]        Reg_addr,
    input  logic [7:0]        Wdata,
    output logic              Busy,
    output logic              Done,
    output logic [7:0]        Rdata,
    output logic [1:0]        Err,
    output logic [AWIDTH-1:0] Addr,
    output logic [DWIDTH-1:0] Dout,
    input  logic [DWIDTH-1:0] Din,
    output logic              Wr
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_PRE,
        S_CFG_CTR,
        S_TXR,
        S_CR,
        S_POLL_A,
        S_POLL_C,
        S_RD_A,
        S_RD_C,
        S_STOP,
        S_IACK,
        S_DONE
    } state_t;

    localparam logic [11:0] TO_LAST = 12'(TO_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic              cfg_done;
    logic              rnw_q;
    logic [6:0]        slv_q;
    logic [7:0]        reg_q;
    logic [7:0]        wdata_q;
    logic [1:0]        phase;
    logic [11:0]       poll_cnt;
    logic              stopping;
    logic [1:0]        err_q;
    logic [7:0]        rdata_q;
    logic [7:0]        txr_val;
    logic [7:0]        cr_val;
    logic [AWIDTH-1:0] bus_addr;
    logic [7:0]        bus_data;
    logic              bus_wr;
    logic              tip;
    logic              al;
    logic              rxack;
    logic              last_byte;
    logic              to_hit;

    assign tip       = Din[1];
    assign al        = Din[5];
    assign rxack     = Din[7];
    assign to_hit    = (poll_cnt == TO_LAST);
    assign last_byte = (phase == 2'd3) || (!rnw_q && phase == 2'd2);

    // Phase 2 is the data byte for writes and the repeated start for reads
    always_comb begin
        txr_val = 8'h00;
        cr_val  = 8'h00;
        unique case (phase)
            2'd0: begin
                txr_val = {slv_q, 1'b0};
                cr_val  = 8'h90;
            end
            2'd1: begin
                txr_val = reg_q;
                cr_val  = 8'h10;
            end
            2'd2: begin
                txr_val = rnw_q ? {slv_q, 1'b1} : wdata_q;
                cr_val  = rnw_q ? 8'h90 : 8'h50;
            end
            2'd3: begin
                txr_val = 8'h00;
                cr_val  = 8'h68;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus_addr = '0;
        bus_data = 8'h00;
        bus_wr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Req) state_d = cfg_done ? S_TXR : S_CFG_PRE;
            end
            S_CFG_PRE: begin
                bus_addr = PRER_A;
                bus_data = PRESCALE;
                bus_wr   = 1'b1;
                state_d  = S_CFG_CTR;
            end
            S_CFG_CTR: begin
                bus_addr = CTR_A;
                bus_data = 8'h80;
                bus_wr   = 1'b1;
                state_d  = S_TXR;
            end
            S_TXR: begin
                bus_addr = TXR_A;
                bus_data = txr_val;
                bus_wr   = 1'b1;
                state_d  = S_CR;
            end
            S_CR: begin
                bus_addr = CR_A;
                bus_data = cr_val;
                bus_wr   = 1'b1;
                state_d  = S_POLL_A;
            end
            S_POLL_A: begin
                bus_addr = SR_A;
                state_d  = S_POLL_C;
            end
            S_POLL_C: begin
                bus_addr = SR_A;
                if (tip) begin
                    if (!to_hit) state_d = S_POLL_A;
                    else state_d = stopping ? S_DONE : S_STOP;
                end else if (stopping) begin
                    state_d = S_DONE;
                end else if (al) begin
                    state_d = S_IACK;
                end else if (rxack && phase != 2'd3) begin
                    state_d = S_STOP;
                end else if (last_byte) begin
                    state_d = rnw_q ? S_RD_A : S_DONE;
                end else if (rnw_q && phase == 2'd2) begin
                    state_d = S_CR;
                end else begin
                    state_d = S_TXR;
                end
            end
            S_RD_A: begin
                bus_addr = RXR_A;
                state_d  = S_RD_C;
            end
            S_RD_C: begin
                bus_addr = RXR_A;
                state_d  = S_DONE;
            end
            S_STOP: begin
                bus_addr = CR_A;
                bus_data = 8'h40;
                bus_wr   = 1'b1;
                state_d  = S_POLL_A;
            end
            S_IACK: begin
                bus_addr = CR_A;
                bus_data = 8'h01;
                bus_wr   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Once stopping is set, the outcome of the stop wait never alters Err
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cfg_done <= 1'b0;
            rnw_q    <= 1'b0;
            slv_q    <= 7'h00;
            reg_q    <= 8'h00;
            wdata_q  <= 8'h00;
            phase    <= 2'd0;
            poll_cnt <= 12'd0;
            stopping <= 1'b0;
            err_q    <= 2'b00;
            rdata_q  <= 8'h00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Req) begin
                        rnw_q    <= Rnw;
                        slv_q    <= Slv_addr;
                        reg_q    <= Reg_addr;
                        wdata_q  <= Wdata;
                        phase    <= 2'd0;
                        stopping <= 1'b0;
                        err_q    <= 2'b00;
                    end
                end
                S_CFG_CTR: cfg_done <= 1'b1;
                S_CR:      poll_cnt <= 12'd0;
                S_STOP: begin
                    poll_cnt <= 12'd0;
                    stopping <= 1'b1;
                end
                S_POLL_C: begin
                    if (tip) begin
                        if (!to_hit) poll_cnt <= poll_cnt + 12'd1;
                        else if (!stopping) err_q <= 2'b11;
                    end else if (!stopping) begin
                        if (al) err_q <= 2'b10;
                        else if (rxack && phase != 2'd3) err_q <= 2'b01;
                        else if (!last_byte) phase <= phase + 2'd1;
                    end
                end
                S_RD_C:  rdata_q <= Din[7:0];
                default: ;
            endcase
        end
    end

    assign Addr  = bus_addr;
    assign Dout  = DWIDTH'(bus_data);
    assign Wr    = bus_wr;
    assign Busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done  = (state_q == S_DONE);
    assign Err   = err_q;
    assign Rdata = rdata_q;

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// tb_i2c_seq_ctrl: randomized transactions against a register-bus slave
// model; expected bus writes and results come from the sequencing rules.
module tb_i2c_seq_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       rnw = 1'b0;
    logic [6:0] slv = '0;
    logic [7:0] rega = '0;
    logic [7:0] wdata = '0;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [1:0] err;
    logic [2:0] addr;
    logic [7:0] dout;
    logic [7:0] din;
    logic       wr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2c_seq_ctrl #(.TO_CYCLES(TO)) dut (
        .Clk(clk), .Rst_n(rst_n), .Req(req), .Rnw(rnw),
        .Slv_addr(slv), .Reg_addr(rega), .Wdata(wdata),
        .Busy(busy), .Done(done), .Rdata(rdata), .Err(err),
        .Addr(addr), .Dout(dout), .Din(din), .Wr(wr)
    );

    // slave register model
    int         m_delay = 0;
    int         m_nack_at = -1;
    int         m_al_at = -1;
    bit         m_stuck = 0;
    logic [7:0] m_rxr = '0;
    int         tip_cnt = 0;
    bit         sr_rx = 0;
    bit         sr_al = 0;
    int         byte_k = 0;
    int         sr_reads = 0;
    logic [10:0] act_q[$];
    int          gap_q[$];

    always @(negedge clk) begin
        if (wr) begin
            act_q.push_back({addr, dout});
            gap_q.push_back(sr_reads);
            sr_reads = 0;
            if (addr == 3'h3) begin
                tip_cnt = m_delay;
                if (dout == 8'h40 || dout == 8'h01) begin
                    sr_rx = 0;
                    sr_al = 0;
                end else begin
                    sr_rx = (byte_k == m_nack_at);
                    sr_al = (byte_k == m_al_at);
                    byte_k++;
                end
            end
        end else begin
            if (addr == 3'h3) sr_reads++;
            if (tip_cnt > 0) tip_cnt--;
        end
    end

    always_comb begin
        din = 8'h00;
        if (addr == 3'h3)
            din = {sr_rx, 1'b0, sr_al, 3'b000, (m_stuck || tip_cnt != 0), 1'b0};
        else if (addr == 3'h2)
            din = m_rxr;
    end

    // reference model
    logic [10:0] exp_q[$];
    logic [1:0]  exp_err;
    logic [7:0]  exp_rd;
    bit          cfg_known = 0;

    task automatic build_exp(input bit r, input logic [6:0] s, input logic [7:0] ra,
                             input logic [7:0] w, input logic [7:0] x, input int d,
                             input int nk, input int al, input bit st);
        int nb;
        logic [7:0] tx;
        logic [7:0] cr;
        exp_q.delete();
        exp_err = 2'b00;
        exp_rd = x;
        if (!cfg_known) begin
            exp_q.push_back({3'h0, 8'd49});
            exp_q.push_back({3'h1, 8'h80});
        end
        nb = r ? 4 : 3;
        for (int b = 0; b < nb; b++) begin
            case (b)
                0: begin tx = {s, 1'b0}; cr = 8'h90; end
                1: begin tx = ra; cr = 8'h10; end
                2: begin tx = r ? {s, 1'b1} : w; cr = r ? 8'h90 : 8'h50; end
                default: begin tx = 8'h00; cr = 8'h68; end
            endcase
            if (b != 3) exp_q.push_back({3'h2, tx});
            exp_q.push_back({3'h3, cr});
            // each poll spans two cycles of TIP countdown
            if (st || (d + 1) / 2 > TO) begin
                exp_q.push_back({3'h3, 8'h40});
                exp_err = 2'b11;
                return;
            end
            if (al == b) begin
                exp_q.push_back({3'h3, 8'h01});
                exp_err = 2'b10;
                return;
            end
            if (nk == b && b < 3) begin
                exp_q.push_back({3'h3, 8'h40});
                exp_err = 2'b01;
                return;
            end
        end
    endtask

    function automatic int first_diff();
        if (act_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (act_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    logic [1:0] o_err;
    logic [7:0] o_rd;
    logic       o_busy;
    logic       o_done2;
    int         o_lat;

    task automatic do_txn(input bit r, input logic [6:0] s, input logic [7:0] ra,
                          input logic [7:0] w, input logic [7:0] x, input int d,
                          input int nk, input int al, input bit st, input int breq);
        build_exp(r, s, ra, w, x, d, nk, al, st);
        @(negedge clk);
        m_delay = d; m_nack_at = nk; m_al_at = al; m_stuck = st; m_rxr = x;
        byte_k = 0; sr_reads = 0;
        act_q.delete(); gap_q.delete();
        rnw = r; slv = s; rega = ra; wdata = w; req = 1'b1;
        o_lat = 0;
        do begin
            @(negedge clk);
            o_lat++;
            req = (o_lat == breq);
            if (req) begin
                rnw = ~r; slv = ~s; rega = ~ra; wdata = ~w;
            end
        end while (!done && o_lat < 3000);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_bound: got no Done after %0d cycles want Done", o_lat);
        end
        o_err = err; o_rd = rdata; o_busy = busy;
        @(negedge clk);
        o_done2 = done;
        m_stuck = 0;
        cfg_known = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, wr} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b want 000", {busy, done, wr});
        end
        checks++;
        if ({err, rdata} !== 10'h000) begin
            errors++; $display("FAIL reset_res: got %h want 000", {err, rdata});
        end
        checks++;
        if ({addr, dout} !== 11'h000) begin
            errors++; $display("FAIL reset_bus: got %h want 000", {addr, dout});
        end
        rst_n = 1'b1;
        cfg_known = 0;
    endtask

    task automatic test_write();
        do_txn(0, 7'h50, 8'h10, 8'hA5, 8'h00, 10, -1, -1, 0, 0);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL write_seq: got %0d writes diff@%0d want %0d", act_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if (o_err !== exp_err) begin
            errors++; $display("FAIL write_err: got %0d want %0d", o_err, exp_err);
        end
        checks++;
        if ({o_busy, o_done2} !== 2'b00) begin
            errors++; $display("FAIL write_done: got %b want 00", {o_busy, o_done2});
        end
    endtask

    task automatic test_read();
        do_txn(1, 7'h50, 8'h03, 8'h00, 8'h3C, 10, -1, -1, 0, 0);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL read_seq: got %0d writes diff@%0d want %0d", act_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if ({o_err, o_rd} !== {2'b00, 8'h3C}) begin
            errors++; $display("FAIL read_data: got %h want 03c", {o_err, o_rd});
        end
    endtask

    task automatic test_nack();
        do_txn(0, 7'h21, 8'h44, 8'h99, 8'h00, 4, 0, -1, 0, 0);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL nack_seq: got %0d writes diff@%0d want %0d", act_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if (o_err !== 2'b01) begin
            errors++; $display("FAIL nack_err: got %0d want 1", o_err);
        end
    endtask

    task automatic test_al();
        do_txn(0, 7'h33, 8'h55, 8'h66, 8'h00, 6, -1, 1, 0, 0);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL al_seq: got %0d writes diff@%0d want %0d", act_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if (o_err !== 2'b10) begin
            errors++; $display("FAIL al_err: got %0d want 2", o_err);
        end
    endtask

    task automatic test_timeout();
        do_txn(0, 7'h0F, 8'h01, 8'h02, 8'h00, 0, -1, -1, 1, 0);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL to_seq: got %0d writes diff@%0d want %0d", act_q.size(), first_diff(), exp_q.size());
        end
        checks++;
        if (o_err !== 2'b11) begin
            errors++; $display("FAIL to_err: got %0d want 3", o_err);
        end
        checks++;
        if (gap_q.size() < 3 || gap_q[2] != 2 * TO) begin
            errors++; $display("FAIL to_polls: got %0d read cycles want %0d", gap_q.size() > 2 ? gap_q[2] : -1, 2 * TO);
        end
        do_txn(0, 7'h11, 8'h22, 8'h33, 8'h00, 2 * TO, -1, -1, 0, 0);
        checks++;
        if (o_err !== exp_err || first_diff() != -1) begin
            errors++; $display("FAIL to_edge_ok: got err %0d want %0d", o_err, exp_err);
        end
        do_txn(0, 7'h11, 8'h22, 8'h33, 8'h00, 2 * TO + 1, -1, -1, 0, 0);
        checks++;
        if (o_err !== exp_err || first_diff() != -1) begin
            errors++; $display("FAIL to_edge_hit: got err %0d want %0d", o_err, exp_err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit r;
            int nk;
            int al;
            r  = 1'($urandom_range(0, 1));
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r ? 3 : 2)) : -1;
            al = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r ? 3 : 2)) : -1;
            do_txn(r, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 12)), nk, al, 0, 0);
            checks++;
            if (first_diff() != -1 || o_err !== exp_err) begin
                errors++; $display("FAIL rand_%0d: got err %0d diff@%0d want err %0d", i, o_err, first_diff(), exp_err);
            end
            if (r && exp_err == 2'b00) begin
                checks++;
                if (o_rd !== exp_rd) begin
                    errors++; $display("FAIL rand_rd_%0d: got %h want %h", i, o_rd, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m_delay = 0; m_stuck = 0; m_nack_at = -1; m_al_at = -1; byte_k = 0;
        rnw = 0; slv = 7'h2A; rega = 8'h77; wdata = 8'h11; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({wr, addr, dout} !== {1'b1, 3'h2, 8'h77}) begin
            errors++; $display("FAIL mid_p1: got %h want a77", {wr, addr, dout});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wr, busy} !== 2'b00) begin
            errors++; $display("FAIL mid_reset: got %b want 00", {wr, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cfg_known = 0;
        do_txn(0, 7'h2A, 8'h77, 8'h11, 8'h00, 0, -1, -1, 0, 0);
        checks++;
        if (first_diff() != -1 || o_lat != 15) begin
            errors++; $display("FAIL mid_recfg: got lat %0d diff@%0d want lat 15", o_lat, first_diff());
        end
        do_txn(0, 7'h2A, 8'h78, 8'h12, 8'h00, 0, -1, -1, 0, 0);
        checks++;
        if (first_diff() != -1 || o_lat != 13) begin
            errors++; $display("FAIL lat_cfgd: got lat %0d diff@%0d want lat 13", o_lat, first_diff());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_txn(0, 7'h45, 8'h9A, 8'h5C, 8'h00, 3, -1, -1, 0, 4);
        checks++;
        if (first_diff() != -1 || o_err !== 2'b00) begin
            errors++; $display("FAIL busy_req: got err %0d diff@%0d want err 0", o_err, first_diff());
        end
        n = act_q.size();
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || act_q.size() != n) begin
            errors++; $display("FAIL busy_queued: got busy %b writes %0d want 0 %0d", busy, act_q.size(), n);
        end
        do_txn(1, 7'h45, 8'h9B, 8'h00, 8'hE7, 0, -1, -1, 0, 0);
        checks++;
        if (first_diff() != -1 || o_rd !== 8'hE7) begin
            errors++; $display("FAIL b2b_read: got %h diff@%0d want e7", o_rd, first_diff());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_al();
        test_timeout();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_seq_ctrl.md
Name: i2c_seq_ctrl

Overview:
Transaction sequencer that drives the i2c_master_regs system data bus, taking the place of a CPU. It turns one user request into the full register-programming sequence for an I2C register write or register read: prescale/enable configuration, start plus slave address, register address, data, and stop. It polls the status register (SR) for completion and reports NACK, arbitration-lost and timeout errors.

Parameters:
- AWIDTH, 3, register bus address width
- DWIDTH, 8, register bus data width
- PRESCALE, 8'd49, value written to PRER during configuration
- TO_CYCLES, 4095, maximum poll cycles per byte before timeout (12-bit counter)
- PRER_A, 3'h0 / CTR_A, 3'h1 / TXR_A, 3'h2 / RXR_A, 3'h2 / CR_A, 3'h3 / SR_A, 3'h3, register addresses

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Req  in  1  start transaction; sampled only in IDLE
- Rnw  in  1  1 = register read, 0 = register write
- Slv_addr  in  7  I2C slave address
- Reg_addr  in  8  slave register index
- Wdata  in  8  write data
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle pulse at end of transaction (success or error)
- Rdata  out  8  read result, valid from Done
- Err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout; valid from Done
- Addr  out  AWIDTH  register bus address
- Dout  out  DWIDTH  register bus write data
- Din  in  DWIDTH  register bus read data (combinational from Addr)
- Wr  out  1  register write strobe, one cycle per write

Behaviour:
- Reset: all outputs 0; state IDLE; cfg_done = 0.
- Bus write: Addr, Dout and Wr=1 are held for exactly one cycle.
- Bus read: Addr is driven in cycle N; Din is sampled at the end of cycle N+1 (two-state POLL_A/POLL_C pair).
- CR bit layout: STA=7, STO=6, RD=5, WR=4, ACK=3, IACK=0.
- SR bit layout: RxACK=7, AL=5, TIP=1.
- CTR layout: EN=7; the block writes 8'h80 (interrupts unused).
- IDLE + Req: latch all inputs, set Busy=1.
  - If cfg_done=0: go to CFG_PRE (write PRER), then CFG_CTR (write CTR), set cfg_done=1.
  - Otherwise go directly to the byte phases.
- Byte phase step: write TXR, then write CR, then wait.
- Wait sequence (WAIT): POLL_A/POLL_C loop until SR.TIP=0.
  - Checks at completion, in priority order: AL=1 -> Err=10; RxACK=1 on a write byte -> Err=01.
  - The poll counter increments every POLL_C. Reaching TO_CYCLES -> Err=11.
- Write sequence, with CR values:
  - P0: TXR={Slv,0}, CR=8'h90
  - P1: TXR=Reg_addr, CR=8'h10
  - P2: TXR=Wdata, CR=8'h50
- Read sequence, with CR values:
  - P0: TXR={Slv,0}, CR=8'h90
  - P1: TXR=Reg_addr, CR=8'h10
  - P2: TXR={Slv,1}, CR=8'h90 (repeated start)
  - P3: CR=8'h68 (RD, NACK, STO); no RxACK check on P3
  - RD_RXR: read RXR into Rdata.
- Error handling:
  - NACK or timeout: write CR=8'h40 (stop), wait for TIP=0 with no further checks, then go to DONE.
  - AL: write CR=8'h01 (IACK), no stop, then go to DONE.
  - The first error wins; later errors in the same transaction are ignored.
- DONE: Done=1 for one cycle, Busy=0, return to IDLE.
  - Rdata and Err hold until the next Req is accepted; Err clears on acceptance.
- Req while Busy is ignored and not queued.
- Reset mid-transaction returns the block to IDLE with Wr=0 and cfg_done=0, so PRER/CTR are reprogrammed on the next Req.
- Latency (zero-wait core, TIP=0 at the first poll):
  - Write, configured: 3 phases × 4 cycles + 1 DONE = 13 cycles from Req to Done.
  - First transaction: +2 cycles for configuration.
- The poll counter resets at the start of each byte phase.

Test Plan:
- Write, slave ACKs: Slv=7'h50, Reg=8'h10, Wdata=8'hA5, regs model clears TIP after 10 cycles, RxACK=0 -> bus writes in order: PRER=49, CTR=80, TXR=A0, CR=90, TXR=10, CR=10, TXR=A5, CR=50; Done pulse with Err=00; Busy low afterwards.
- Read: Slv=7'h50, Reg=8'h03, model RXR=8'h3C -> extra TXR=A1, CR=90, CR=68, RXR read; Rdata=8'h3C, Err=00; no PRER/CTR writes on this second transaction.
- NACK on address byte: RxACK=1 after P0 -> CR=40 written, no TXR=Reg write, Done with Err=01.
- Arbitration lost in P1: SR.AL=1 -> CR=01 written, no stop written, Err=10.
- Timeout: TIP stuck at 1 with TO_CYCLES=16 -> Err=11 after 16 polls; stop issued; Done asserted.
- Reset asserted mid-P1, then Req again -> Wr=0 immediately on reset; next transaction restarts with PRER/CTR writes; Req asserted while Busy has no effect.
